// File: rtl/leb128_stream_dec_pkg.sv
// leb128_pkg: shared constants and helpers for the LEB128 stream decoder and
// its group-merge datapath (also intended for the future encoder checker).
//   leb128_maxlen(w) : number of 7-bit groups needed to cover w bits
//   LEB_CONT_BIT     : continuation flag position inside an encoded byte
//   LEB_GRP          : payload bits per encoded byte
//   ST_*             : decoder FSM state encodings
package leb128_pkg;
  localparam int LEB_CONT_BIT = 7;
  localparam int LEB_GRP      = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int leb128_maxlen(input int w);
    return (w + LEB_GRP - 1) / LEB_GRP;
  endfunction
endpackage

// File: rtl/leb128_stream_dec_if.sv
// leb128_stream_dec_if: byte-in / value-out handshake bundle of the decoder.
//   in_data/in_valid/in_ready/is_signed : encoded byte stream
//   out_data/out_len/out_err/out_valid/out_ready : decoded result
//   master : byte producer + result consumer ; slave : the decoder
interface leb128_stream_dec_if #(parameter int W = 64);
  import leb128_pkg::*;
  localparam int MAXLEN = leb128_maxlen(W);
  localparam int LEN_W  = $clog2(MAXLEN + 1);

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [W-1:0]     out_data;
  logic [LEN_W-1:0] out_len;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, is_signed, out_ready,
    input  in_ready, out_data, out_len, out_err, out_valid
  );

  modport slave (
    input  in_data, in_valid, is_signed, out_ready,
    output in_ready, out_data, out_len, out_err, out_valid
  );
endinterface

// File: rtl/leb128_stream_dec_grp_merge.sv
// leb128_grp_merge: combinational merge of one 7-bit LEB128 group into a
// W-bit accumulator.
//   acc    : value accumulated from earlier groups
//   grp_in : payload bits of the current byte
//   cnt    : index of the current byte (0-based)
//   sgn    : signed decode
//   last   : current byte is the terminator (enables sign fill)
//   merged : acc with the group placed at 7*cnt, plus sign fill when applicable
module leb128_grp_merge
  import leb128_pkg::*;
#(
  parameter int W     = 64,
  parameter int LEN_W = 4
) (
  input  logic [W-1:0]       acc,
  input  logic [6:0]         grp_in,
  input  logic [LEN_W-1:0]   cnt,
  input  logic               sgn,
  input  logic               last,
  output logic [W-1:0]       merged
);
  localparam logic [7:0] W8 = 8'(W);

  logic [7:0]   sh, sh_next;
  logic [W-1:0] grp, fill;

  assign sh      = 8'(cnt) * 8'(LEB_GRP);
  assign sh_next = sh + 8'(LEB_GRP);

  // group bits that land at or above W fall off the top of the shift
  assign grp  = W'(grp_in) << sh;
  // bit6 of the terminator is the sign; only fill if it leaves bits uncovered
  assign fill = (last && sgn && grp_in[LEB_GRP-1] && (sh_next < W8))
                ? ({W{1'b1}} << sh_next) : '0;

  assign merged = acc | grp | fill;
endmodule

// File: rtl/leb128_stream_dec.sv
// leb128_stream_dec: byte-serial LEB128 decoder. Takes one encoded byte per
// cycle, emits a W-bit value with the number of bytes consumed and an overlong
// error flag one cycle after the terminating (or MAXLEN-th) byte.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : leb128_stream_dec_if slave (byte stream in, result out)
module leb128_stream_dec
  import leb128_pkg::*;
#(
  parameter int W = 64
) (
  input logic               clk,
  input logic               rst_n,
  leb128_stream_dec_if.slave bus
);
  localparam int MAXLEN = leb128_maxlen(W);
  localparam int LEN_W  = $clog2(MAXLEN + 1);

  logic [1:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [W-1:0]     acc, merged;
  logic             sgn_q, cur_sgn;
  logic             fire, cont, overlong;

  logic [W-1:0]     out_data_q;
  logic [LEN_W-1:0] out_len_q;
  logic             out_err_q, out_valid_q;

  // a held result blocks input; consuming it frees the slot in the same cycle
  assign bus.in_ready  = !(out_valid_q && !bus.out_ready);
  assign bus.out_data  = out_data_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;

  assign fire     = bus.in_valid && bus.in_ready;
  assign cont     = bus.in_data[LEB_CONT_BIT];
  assign cur_sgn  = (state == ST_IDLE) ? bus.is_signed : sgn_q;
  assign overlong = cont && (cnt == LEN_W'(MAXLEN - 1));

  leb128_grp_merge #(.W(W), .LEN_W(LEN_W)) u_merge (
    .acc    (acc),
    .grp_in (bus.in_data[6:0]),
    .cnt    (cnt),
    .sgn    (cur_sgn),
    .last   (!cont),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      sgn_q       <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (fire) begin
        if (state == ST_DRAIN) begin
          if (!cont) state <= ST_IDLE;
        end else if (!cont || overlong) begin
          // terminator or MAXLEN-th continuation byte: publish and restart;
          // merge applies no sign fill when cont=1, so overlong keeps the partial
          out_valid_q <= 1'b1;
          out_data_q  <= merged;
          out_len_q   <= cnt + 1'b1;
          out_err_q   <= cont;
          acc         <= '0;
          cnt         <= '0;
          state       <= cont ? ST_DRAIN : ST_IDLE;
        end else begin
          acc   <= merged;
          cnt   <= cnt + 1'b1;
          sgn_q <= cur_sgn;
          state <= ST_ACC;
        end
      end
    end
  end
endmodule

// File: tb/tb_leb128_stream_dec.sv
// Bench for leb128_stream_dec: a W=64 and a W=32 instance share the clock and
// reset. A behavioural decoder model predicts out_valid/in_ready/result every
// cycle; directed LEB128 cases pin literal values, then randomized streams with
// random backpressure and gaps exercise both widths.
module tb_leb128_stream_dec;
  typedef struct {
    logic [63:0] d;
    int          len;
    logic        e;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  in_data[2];
  logic        in_valid[2], is_signed[2], out_ready[2];
  logic [63:0] od[2];
  logic [3:0]  ol[2];
  logic        oe[2], ov[2], ir[2];

  leb128_stream_dec_if #(.W(64)) b64();
  leb128_stream_dec_if #(.W(32)) b32();

  assign b64.in_data   = in_data[0];
  assign b64.in_valid  = in_valid[0];
  assign b64.is_signed = is_signed[0];
  assign b64.out_ready = out_ready[0];
  assign b32.in_data   = in_data[1];
  assign b32.in_valid  = in_valid[1];
  assign b32.is_signed = is_signed[1];
  assign b32.out_ready = out_ready[1];

  assign od[0] = b64.out_data;
  assign ol[0] = b64.out_len;
  assign oe[0] = b64.out_err;
  assign ov[0] = b64.out_valid;
  assign ir[0] = b64.in_ready;
  assign od[1] = {32'd0, b32.out_data};
  assign ol[1] = {1'b0, b32.out_len};
  assign oe[1] = b32.out_err;
  assign ov[1] = b32.out_valid;
  assign ir[1] = b32.in_ready;

  leb128_stream_dec #(.W(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));
  leb128_stream_dec #(.W(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));

  int errors = 0;
  int checks = 0;
  res_t lg0[$], lg1[$];
  logic rnd_on = 1'b0;

  task automatic chk(input int k, input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL k%0d %s: got %h want %h at %0t", k, nm, a, e, $time);
    end
  endtask

  function automatic int wof(input int k);
    return (k == 0) ? 64 : 32;
  endfunction
  function automatic int mlen(input int k);
    return (wof(k) + 6) / 7;
  endfunction
  function automatic logic [63:0] wmask(input int k);
    return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // ---------------- behavioural model ----------------
  logic        exp_v[2];
  logic [63:0] exp_d[2];
  int          exp_l[2];
  logic        exp_e[2];
  int          m_n[2];
  logic        m_dr[2], m_s[2];
  logic [139:0] m_big[2];

  task automatic model_clear(input int k);
    exp_v[k] = 1'b0; m_n[k] = 0; m_dr[k] = 1'b0; m_big[k] = '0; m_s[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    logic rdy;
    logic [7:0] b;
    logic [63:0] v;
    rdy = !(exp_v[k] && !out_ready[k]);
    if (exp_v[k] && out_ready[k]) exp_v[k] = 1'b0;
    if (in_valid[k] && rdy) begin
      b = in_data[k];
      if (m_dr[k]) begin
        if (!b[7]) m_dr[k] = 1'b0;
      end else begin
        if (m_n[k] == 0) m_s[k] = is_signed[k];
        m_big[k] = m_big[k] | (140'(b[6:0]) << (7 * m_n[k]));
        m_n[k]++;
        if (!b[7]) begin
          v = m_big[k][63:0];
          if (m_s[k] && (7 * m_n[k] < wof(k)) && b[6]) v = v | (~64'd0 << (7 * m_n[k]));
          exp_d[k] = v & wmask(k); exp_l[k] = m_n[k]; exp_e[k] = 1'b0; exp_v[k] = 1'b1;
          m_n[k] = 0; m_big[k] = '0;
        end else if (m_n[k] == mlen(k)) begin
          exp_d[k] = m_big[k][63:0] & wmask(k); exp_l[k] = m_n[k]; exp_e[k] = 1'b1;
          exp_v[k] = 1'b1; m_dr[k] = 1'b1; m_n[k] = 0; m_big[k] = '0;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) model_clear(k);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) model_clear(k);
        else model_step(k);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk(k, "out_valid", 64'(ov[k]), 64'(exp_v[k]));
        chk(k, "in_ready", 64'(ir[k]), 64'(!(exp_v[k] && !out_ready[k])));
        if (exp_v[k]) begin
          chk(k, "out_data", od[k], exp_d[k]);
          chk(k, "out_len", 64'(ol[k]), 64'(exp_l[k]));
          chk(k, "out_err", 64'(oe[k]), 64'(exp_e[k]));
        end
        if (ov[k] && out_ready[k]) begin
          res_t r;
          r.d = od[k]; r.len = int'(ol[k]); r.e = oe[k];
          if (k == 0) lg0.push_back(r); else lg1.push_back(r);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int k, input logic [7:0] b, input logic s);
    logic got;
    got = 1'b0;
    in_data[k] = b; in_valid[k] = 1'b1; is_signed[k] = s;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = ir[k];
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL k%0d send timeout: in_ready stayed 0, wanted 1", k);
    end
    in_valid[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    lg0.delete(); lg1.delete();
  endtask

  task automatic pop_chk(input int k, input logic [63:0] d, input int len, input logic e, input string nm);
    res_t r;
    int sz;
    sz = (k == 0) ? lg0.size() : lg1.size();
    if (sz == 0) begin
      checks++; errors++;
      $display("FAIL k%0d %s: no result, want data=%h", k, nm, d);
    end else begin
      if (k == 0) r = lg0.pop_front(); else r = lg1.pop_front();
      chk(k, {nm, " data"}, r.d, d);
      chk(k, {nm, " len"}, 64'(r.len), 64'(len));
      chk(k, {nm, " err"}, 64'(r.e), 64'(e));
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int ln, gap;
    logic [7:0] b;
    logic s;
    for (int k = 0; k < 2; k++) begin
      in_data[k] = 8'h00; in_valid[k] = 1'b0; is_signed[k] = 1'b0; out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst out_valid", 64'(ov[k]), 64'd0);
      chk(k, "rst out_data", od[k], 64'd0);
      chk(k, "rst out_len", 64'(ol[k]), 64'd0);
      chk(k, "rst out_err", 64'(oe[k]), 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // single byte, one-cycle latency
    clr();
    send(0, 8'h01, 1'b0);
    @(negedge clk);
    chk(0, "t1 latency out_valid", 64'(ov[0]), 64'd1);
    idle(3);
    pop_chk(0, 64'd1, 1, 1'b0, "t1 0x01");

    // 0xFF x9, 0x01 signed -> -1, 10 bytes
    clr();
    for (int i = 0; i < 9; i++) send(0, 8'hFF, 1'b1);
    send(0, 8'h01, 1'b1);
    idle(3);
    pop_chk(0, 64'hFFFF_FFFF_FFFF_FFFF, 10, 1'b0, "t2 minus one");

    // back-to-back values
    clr();
    send(0, 8'h80, 1'b1); send(0, 8'h80, 1'b1); send(0, 8'h80, 1'b1);
    send(0, 8'h80, 1'b1); send(0, 8'h0C, 1'b1);
    send(0, 8'hBC, 1'b1); send(0, 8'h0B, 1'b1);
    idle(3);
    pop_chk(0, 64'h0000_0000_C000_0000, 5, 1'b0, "t3 first");
    pop_chk(0, 64'h0000_0000_0000_05BC, 2, 1'b0, "t3 second");

    // W=32 sign handling
    clr();
    send(1, 8'h7F, 1'b1);
    send(1, 8'h7F, 1'b0);
    idle(3);
    pop_chk(1, 64'hFFFF_FFFF, 1, 1'b0, "t4 signed 7F");
    pop_chk(1, 64'h7F, 1, 1'b0, "t4 unsigned 7F");

    // W=32 overlong, drain, recover
    clr();
    for (int i = 0; i < 6; i++) send(1, 8'h80, 1'b0);
    send(1, 8'h00, 1'b0);
    send(1, 8'h05, 1'b0);
    idle(3);
    pop_chk(1, 64'd0, 5, 1'b1, "t5 overlong");
    pop_chk(1, 64'd5, 1, 1'b0, "t5 after drain");
    chk(1, "t5 no extra", 64'(lg1.size()), 64'd0);

    // backpressure: held result blocks the next byte and stays stable
    clr();
    out_ready[0] = 1'b0;
    send(0, 8'h03, 1'b0);
    in_data[0] = 8'h04; in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(0, "t6 stall in_ready", 64'(ir[0]), 64'd0);
      chk(0, "t6 stall out_data", od[0], 64'd3);
      chk(0, "t6 stall out_valid", 64'(ov[0]), 64'd1);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    send(0, 8'h04, 1'b0);
    idle(3);
    pop_chk(0, 64'd3, 1, 1'b0, "t6 held");
    pop_chk(0, 64'd4, 1, 1'b0, "t6 next");

    // reset mid-value
    clr();
    send(0, 8'h80, 1'b0); send(0, 8'h80, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send(0, 8'h02, 1'b0);
    idle(3);
    pop_chk(0, 64'd2, 1, 1'b0, "t7 after reset");
    chk(0, "t7 no extra", 64'(lg0.size()), 64'd0);

    // randomized streams with random backpressure and gaps
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          if (rnd_on) begin
            out_ready[0] = ($urandom_range(0, 3) != 0);
            out_ready[1] = ($urandom_range(0, 3) != 0);
          end
        end
      end
    join_none
    for (int k = 0; k < 2; k++) begin
      for (int v = 0; v < 250; v++) begin
        ln = ($urandom_range(0, 7) == 0) ? mlen(k) + int'($urandom_range(1, 3))
                                         : int'($urandom_range(1, mlen(k)));
        s = 1'($urandom_range(0, 1));
        for (int j = 0; j < ln; j++) begin
          b = 8'($urandom_range(0, 127));
          if (j < ln - 1) b[7] = 1'b1;
          send(k, b, s);
          gap = int'($urandom_range(0, 5));
          if (gap == 0) idle(1);
        end
      end
    end
    rnd_on = 1'b0;
    @(posedge clk); #2;
    out_ready[0] = 1'b1; out_ready[1] = 1'b1;
    for (int t = 0; t < 50 && (exp_v[0] || exp_v[1]); t++) @(posedge clk);
    #2;
    chk(0, "final drained", 64'(exp_v[0] || exp_v[1]), 64'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
